router_wh_cell: RTL
===================

# router_wh_cell

Wormhole-switched 5-port mesh router cell (N, E, S, W, L). It is the parametrised successor to the single-flit router cell and sits at every mesh tile, with its local port attached to the tile NI. Multi-flit packets (head/body/tail) lock an output for their whole duration. Packets are routed XY from head-flit coordinates, and packets addressed off-mesh are discarded in full.

## Interface
- FLIT_W, 64, flit width; must be ≥ 2*COORD_W+2
- FIFO_DEPTH, 4, per-input FIFO entries; power of 2, ≥ 2
- ROWS, 4, mesh rows
- COLS, 4, mesh columns
- R, 0, this cell's row
- C, 0, this cell's column
- COORD_W, 8, coordinate field width
---
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flit_in_flat  in  5*FLIT_W  input flits, port p at [p*FLIT_W +: FLIT_W], order N,E,S,W,L = 0..4
- valid_in_flat  in  5  input valid per port
- ready_out_flat  out  5  input ready per port (= FIFO not full)
- flit_out_flat  out  5*FLIT_W  output flits
- valid_out_flat  out  5  output valid per port
- ready_in_flat  in  5  downstream ready per port
- err_drop  out  1  one-cycle pulse per flit discarded

## Operation
- Flit type is [FLIT_W-1:FLIT_W-2]:
  - 01 = HEAD
  - 00 = BODY
  - 10 = TAIL
  - 11 = SINGLE (head and tail in one flit)
- Head/single flits carry dest_row in [2*COORD_W-1:COORD_W] and dest_col in [COORD_W-1:0].
- XY routing, rows first:
  - dr<R → N; dr>R → S
  - else dc<C → W; dc>C → E
  - else → L
- Off-mesh: the computed direction is off-mesh if it is N at R==0, S at R==ROWS-1, W at C==0, or E at C==COLS-1.
- Input FIFOs: a push occurs when valid&ready. There is no bypass; a flit pushed at edge N is first visible at the FIFO head in cycle N+1.
- Input state machine, per input, states IDLE / FWD(dir) / DROP:
  - IDLE, head is HEAD/SINGLE, on-mesh: request output dir. On grant and transfer, HEAD → FWD(dir); SINGLE stays IDLE.
  - IDLE, head is HEAD/SINGLE, off-mesh: pop immediately and pulse err_drop. HEAD → DROP.
  - IDLE, head is BODY/TAIL (orphan): pop and pulse err_drop; stay IDLE.
  - FWD: BODY/TAIL flits forward to the locked output with no arbitration. A TAIL transfer releases the lock → IDLE.
  - FWD, head is HEAD/SINGLE (protocol error): the flit is forwarded as body. The lock is released only by TAIL or SINGLE.
  - DROP: pop one flit per cycle with an err_drop pulse, until TAIL/SINGLE → IDLE.
- Output lock: each output records an owner input or FREE. It becomes owned on a HEAD transfer and returns to FREE on a TAIL transfer.
- Arbitration: only FREE outputs arbitrate, and only among IDLE inputs with an on-mesh HEAD/SINGLE request.
  - Round-robin scan starts at rr_ptr[o].
  - On each granted head transfer, rr_ptr[o] ← winner+1, wrapping 4→0.
- Loopback to the requesting input's own port (L→L) is legal.
- Output valid is combinational from the FIFO head of the owning or granted input; the output flit is zero when not valid.
- Pop occurs only on valid_out&ready_in for the selected output, or on a drop.
- err_drop: at most one pulse per cycle. If several inputs drop in the same cycle, only the lowest-index input pops that cycle; the others wait.

## Timing
- Reset values:
  - ready_out_flat = 5'h1F
  - valid_out_flat = 0
  - flit_out_flat = 0
  - err_drop = 0
  - all FIFOs empty, locks FREE, input states IDLE, rr_ptr = 0
- Reset asserted mid-packet flushes everything. A downstream partial packet is the sender's concern.
- Latency: 1 cycle from input acceptance to output valid, with no contention.
- Throughput: 1 flit/cycle per output.
- Full FIFO: ready low. Simultaneous push and pop when full is not accepted (ready is computed before the pop).
- ready_in low: valid and flit held stable, lock retained. Valid is never retracted while ready is low.
- The grant is combinational in the cycle the head is at the FIFO head. The lock is registered at the transfer edge.

## Configuration
- ROUTER_WH_STATS_EN defined:
  - adds input stats_clr (1) and output stats_flat (6*32): per-output forwarded-flit counters 0..4, plus the drop counter at index 5
  - all counters 32-bit, saturating at 32'hFFFFFFFF
  - stats_clr zeroes all counters synchronously and has priority over increments
  - reset value 0
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- R=1,C=1, 4x4 mesh. SINGLE to (1,3) on W input → E output valid the next cycle, identical flit; rr_ptr[E]=4 (winner W=3, +1).
- 3-flit packet N→L (dest (1,1)) while E sends SINGLE to (1,1) one cycle later → L carries H,B,T from N consecutively, then E's flit; no interleave.
- N and S both send HEAD to E in the same cycle, rr_ptr[E]=0 → N wins and completes through TAIL, then S.
- R=0: HEAD with dest_row=0xFF is treated as below, routes S in a 4x4 mesh; R=3 cell with dest_row>3 → err_drop pulses 3 times for a 3-flit packet, no output valid.
- Orphan BODY at an IDLE input → err_drop pulse, FIFO pops, no output.
- ready_in[E]=0 for 10 cycles with a queued packet → flit held stable, ready_out goes low after FIFO_DEPTH accepts; with the macro defined, stats_flat[E] increments only on transfers.

Source files
------------

// File: rtl/router_wh_cell.sv
// router_wh_cell: 5-port (N,E,S,W,L) wormhole mesh router cell with XY routing and per-input FIFOs.
// Define ROUTER_WH_STATS_EN to add per-output flit counters and a drop counter (stats_clr / stats_flat).
module router_wh_cell #(
   parameter int FLIT_W     = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int R          = 0,
   parameter int C          = 0,
   parameter int COORD_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5*FLIT_W-1:0] flit_in_flat,
   input  logic [4:0]          valid_in_flat,
   output logic [4:0]          ready_out_flat,
   output logic [5*FLIT_W-1:0] flit_out_flat,
   output logic [4:0]          valid_out_flat,
   input  logic [4:0]          ready_in_flat,
   output logic                err_drop
`ifdef ROUTER_WH_STATS_EN
   ,
   input  logic                stats_clr,
   output logic [6*32-1:0]     stats_flat
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [COORD_W-1:0] ROW_ID = COORD_W'(R);
   localparam logic [COORD_W-1:0] COL_ID = COORD_W'(C);
   localparam logic [2:0] D_N = 3'd0, D_E = 3'd1, D_S = 3'd2, D_W = 3'd3, D_L = 3'd4;

   // Handshake: a flit moves on a port in any cycle where valid and ready are both high;
   // valid never depends on ready, and ready_out is FIFO-not-full sampled before this cycle's pop.

   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} in_state_e;

   in_state_e         in_state_q [5];
   in_state_e         in_state_d [5];
   logic [4:0]        own_vld_q, own_vld_d;
   logic [2:0]        own_idx_q [5];
   logic [2:0]        own_idx_d [5];
   logic [2:0]        rr_q [5];
   logic [2:0]        rr_d [5];

   logic [FLIT_W-1:0] mem [5][FIFO_DEPTH];
   logic [AW:0]       wr_q [5];
   logic [AW:0]       rd_q [5];
   logic [FLIT_W-1:0] head [5];
   logic [2:0]        route_dir [5];
   logic [2:0]        sel_idx [5];
   logic [4:0]        nonempty, full, push, pop, is_hs, is_tl, off_mesh;
   logic [4:0]        req_vld, drop_want, drop_sel, out_vld, granted, xfer;

   // Head decode, XY route and per-input request / drop intent
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         head[i]     = mem[i][rd_q[i][AW-1:0]];
         nonempty[i] = (wr_q[i] != rd_q[i]);
         full[i]     = (wr_q[i] == {~rd_q[i][AW], rd_q[i][AW-1:0]});
         push[i]     = valid_in_flat[i] & ~full[i];
         is_hs[i]    = head[i][FLIT_W-2];
         is_tl[i]    = head[i][FLIT_W-1];
         if (head[i][2*COORD_W-1:COORD_W] < ROW_ID) begin
            route_dir[i] = D_N;
            off_mesh[i]  = (R == 0);
         end else if (head[i][2*COORD_W-1:COORD_W] > ROW_ID) begin
            route_dir[i] = D_S;
            off_mesh[i]  = (R == ROWS-1);
         end else if (head[i][COORD_W-1:0] < COL_ID) begin
            route_dir[i] = D_W;
            off_mesh[i]  = (C == 0);
         end else if (head[i][COORD_W-1:0] > COL_ID) begin
            route_dir[i] = D_E;
            off_mesh[i]  = (C == COLS-1);
         end else begin
            route_dir[i] = D_L;
            off_mesh[i]  = 1'b0;
         end
         req_vld[i]   = nonempty[i] && (in_state_q[i] == ST_IDLE) && is_hs[i] && !off_mesh[i];
         drop_want[i] = nonempty[i] && ((in_state_q[i] == ST_DROP) ||
                        ((in_state_q[i] == ST_IDLE) && (!is_hs[i] || off_mesh[i])));
      end
      drop_sel = drop_want & (~drop_want + 5'd1);
   end

   // Output side: locked owner or round-robin grant, output mux and pops
   always_comb begin
      logic [2:0] cand;
      cand          = '0;
      pop           = drop_sel;
      flit_out_flat = '0;
      for (int o = 0; o < 5; o++) begin
         sel_idx[o] = '0;
         out_vld[o] = 1'b0;
         granted[o] = 1'b0;
         if (own_vld_q[o]) begin
            sel_idx[o] = own_idx_q[o];
            out_vld[o] = nonempty[own_idx_q[o]];
         end else begin
            for (int k = 0; k < 5; k++) begin
               cand = 3'((int'(rr_q[o]) + k) % 5);
               if (!granted[o] && req_vld[cand] && (route_dir[cand] == 3'(o))) begin
                  granted[o] = 1'b1;
                  sel_idx[o] = cand;
                  out_vld[o] = 1'b1;
               end
            end
         end
         xfer[o] = out_vld[o] & ready_in_flat[o];
         if (out_vld[o]) flit_out_flat[o*FLIT_W +: FLIT_W] = head[sel_idx[o]];
         if (xfer[o]) pop[sel_idx[o]] = 1'b1;
      end
   end

   assign valid_out_flat = out_vld;
   assign ready_out_flat = ~full;
   assign err_drop       = |drop_sel;

   // Next state for input FSMs, output locks and round-robin pointers
   always_comb begin
      in_state_d = in_state_q;
      own_vld_d  = own_vld_q;
      own_idx_d  = own_idx_q;
      rr_d       = rr_q;
      for (int o = 0; o < 5; o++) begin
         if (xfer[o]) begin
            if (granted[o]) begin
               rr_d[o] = (sel_idx[o] == 3'd4) ? 3'd0 : sel_idx[o] + 3'd1;
               if (!is_tl[sel_idx[o]]) begin
                  in_state_d[sel_idx[o]] = ST_FWD;
                  own_vld_d[o]           = 1'b1;
                  own_idx_d[o]           = sel_idx[o];
               end
            end else if (is_tl[sel_idx[o]]) begin
               in_state_d[sel_idx[o]] = ST_IDLE;
               own_vld_d[o]           = 1'b0;
            end
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (drop_sel[i]) begin
            if ((in_state_q[i] == ST_IDLE) && is_hs[i] && !is_tl[i]) in_state_d[i] = ST_DROP;
            else if ((in_state_q[i] == ST_DROP) && is_tl[i])         in_state_d[i] = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         own_vld_q <= '0;
         for (int i = 0; i < 5; i++) begin
            in_state_q[i] <= ST_IDLE;
            own_idx_q[i]  <= '0;
            rr_q[i]       <= '0;
            wr_q[i]       <= '0;
            rd_q[i]       <= '0;
         end
      end else begin
         in_state_q <= in_state_d;
         own_vld_q  <= own_vld_d;
         own_idx_q  <= own_idx_d;
         rr_q       <= rr_d;
         for (int i = 0; i < 5; i++) begin
            if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
            if (pop[i])  rd_q[i] <= rd_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 5; i++)
         if (push[i]) mem[i][wr_q[i][AW-1:0]] <= flit_in_flat[i*FLIT_W +: FLIT_W];
   end

`ifdef ROUTER_WH_STATS_EN
   logic [31:0] cnt_q [6];
   logic [5:0]  cnt_inc;

   assign cnt_inc = {err_drop, xfer};

   always_ff @(posedge clk) begin
      for (int k = 0; k < 6; k++) begin
         if (!rst_n || stats_clr)                 cnt_q[k] <= '0;
         else if (cnt_inc[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 32'd1;
      end
   end

   always_comb begin
      for (int k = 0; k < 6; k++) stats_flat[k*32 +: 32] = cnt_q[k];
   end
`endif

endmodule
